// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, TX state encoding and the sub-word write merge.
package uart_pkg;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_BAUDDIV = 2'd2;
   localparam logic [1:0] OFF_CTRL    = 2'd3;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
   typedef logic [2:0] bit_idx_t;

   // Byte/half accesses replace only the low lane(s); anything else is a full word.
   function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  size);
      case (size)
         3'b000:  apply_strb = {cur[31:8], wdata[7:0]};
         3'b001:  apply_strb = {cur[31:16], wdata[15:0]};
         default: apply_strb = wdata;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and wrap-bit pointers.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_XOR = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (wr_ptr ^ rd_ptr) == FULL_XOR;
   assign empty   = wr_ptr == rd_ptr;
   assign count   = wr_ptr - rd_ptr;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_periph.sv
// Bus-attached 8N1 UART transmitter: register window decode, TX FIFO,
// per-state baud down-counter and LSB-first shift-out.
//
//   state | meaning
//   IDLE  | line high, waiting for tx_en and a queued byte
//   START | start bit (line low) for one baud period
//   DATA  | data bit bit_idx of shreg, LSB first
//   STOP  | stop bit (line high); may chain straight into START
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_2000,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busWe,
   input  logic [31:0] busAddr,
   input  logic [31:0] busWData,
   input  logic [2:0]  strb,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        irq_txempty
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            sel;
   logic [1:0]      off;
   logic            wr_en;
   logic            push;
   logic            pop;
   logic [7:0]      fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [15:0]     baud_div;
   logic [15:0]     div_m1;
   logic            tx_en;
   logic            ovf;
   logic            busy;
   logic [3:0]      status;
   logic            unused_addr;

   tx_state_e state, state_nxt;
   logic [15:0] baud_cnt, baud_cnt_nxt;
   bit_idx_t    bit_idx, bit_idx_nxt;
   logic [7:0]  shreg, shreg_nxt;

   assign sel         = busAddr[31:4] == BASE_ADDR[31:4];
   assign off         = busAddr[3:2];
   assign wr_en       = sel & busWe;
   assign push        = wr_en & (off == OFF_TXDATA);
   assign unused_addr = ^busAddr[1:0];

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys (clk),
      .rst_b   (reset),
      .push    (push),
      .wdata   (busWData[7:0]),
      .pop     (pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_div <= DEFAULT_DIV;
         tx_en    <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (wr_en && off == OFF_BAUDDIV)
            baud_div <= 16'(apply_strb({16'b0, baud_div}, busWData, strb));
         if (wr_en && off == OFF_CTRL)
            tx_en <= busWData[0];
         // A dropped push and a clear in the same cycle leave the flag set.
         if (push && fifo_count == CW'(FIFO_DEPTH))
            ovf <= 1'b1;
         else if (wr_en && off == OFF_STATUS && busWData[STAT_OVF])
            ovf <= 1'b0;
      end
   end

   assign busy        = state != IDLE;
   assign irq_txempty = fifo_empty & ~busy;
   assign status      = {ovf, busy, fifo_empty, fifo_full};

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (off)
            OFF_STATUS:  rdata = {28'b0, status};
            OFF_BAUDDIV: rdata = {16'b0, baud_div};
            OFF_CTRL:    rdata = {31'b0, tx_en};
            default:     rdata = '0;
         endcase
      end
   end

   // Counter is loaded with period-1 on every state/bit entry, so a zero divisor acts as one.
   assign div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shreg    <= shreg_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_idx_nxt  = bit_idx;
      shreg_nxt    = shreg;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (tx_en && !fifo_empty) begin
               pop          = 1'b1;
               shreg_nxt    = fifo_rdata;
               state_nxt    = START;
               baud_cnt_nxt = div_m1;
            end
         end
         START: begin
            if (baud_cnt == 16'd0) begin
               state_nxt    = DATA;
               bit_idx_nxt  = '0;
               baud_cnt_nxt = div_m1;
            end else begin
               baud_cnt_nxt = baud_cnt - 16'd1;
            end
         end
         DATA: begin
            if (baud_cnt == 16'd0) begin
               baud_cnt_nxt = div_m1;
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_idx_nxt = bit_idx + 3'd1;
            end else begin
               baud_cnt_nxt = baud_cnt - 16'd1;
            end
         end
         STOP: begin
            if (baud_cnt == 16'd0) begin
               if (tx_en && !fifo_empty) begin
                  pop          = 1'b1;
                  shreg_nxt    = fifo_rdata;
                  state_nxt    = START;
                  baud_cnt_nxt = div_m1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               baud_cnt_nxt = baud_cnt - 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign tx = (state == START) ? 1'b0 :
               (state == DATA)  ? shreg[bit_idx] : 1'b1;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register access, frame timing, FIFO
// overflow, divisor changes and asynchronous reset.
module tb_uart_tx_periph;

   localparam logic [31:0] A_TX   = 32'h1000_2000;
   localparam logic [31:0] A_ST   = 32'h1000_2004;
   localparam logic [31:0] A_BAUD = 32'h1000_2008;
   localparam logic [31:0] A_CTRL = 32'h1000_200C;
   localparam logic [2:0]  SZ_B   = 3'b000;
   localparam logic [2:0]  SZ_H   = 3'b001;
   localparam logic [2:0]  SZ_W   = 3'b010;

   logic        clk;
   logic        reset;
   logic        busWe;
   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic [2:0]  strb;
   logic [31:0] rdata;
   logic        tx;
   logic        irq_txempty;

   int   n_vec = 0;
   int   n_bad = 0;
   logic exp_q[$];

   uart_tx_periph dut (
      .clk         (clk),
      .reset       (reset),
      .busWe       (busWe),
      .busAddr     (busAddr),
      .busWData    (busWData),
      .strb        (strb),
      .rdata       (rdata),
      .tx          (tx),
      .irq_txempty (irq_txempty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; the write lands on the next rising edge.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      busAddr  = a;
      busWData = d;
      strb     = s;
      busWe    = 1'b1;
      @(negedge clk);
      busWe    = 1'b0;
      busAddr  = 32'h0;
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      busWe   = 1'b0;
      busAddr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic add_bits(input logic v, input int n);
      repeat (n) exp_q.push_back(v);
   endtask

   task automatic add_frame(input logic [7:0] b, input int d);
      add_bits(1'b0, d);
      for (int i = 0; i < 8; i++) add_bits(b[i], d);
      add_bits(1'b1, d);
   endtask

   // Compares tx against exp_q one falling edge at a time; optionally writes
   // BAUDDIV on the rising edge preceding sample wr_k.
   task automatic watch(input string tag, input int wr_k, input logic [31:0] wr_val);
      int n;
      n = exp_q.size();
      for (int k = 1; k <= n; k++) begin
         if (k == wr_k) begin
            busAddr  = A_BAUD;
            busWData = wr_val;
            strb     = SZ_W;
            busWe    = 1'b1;
         end else begin
            busWe   = 1'b0;
            busAddr = A_ST;
         end
         @(negedge clk);
         chk({tag, "_tx"}, {31'b0, tx}, {31'b0, exp_q[k-1]});
         chk({tag, "_irq"}, {31'b0, irq_txempty}, 32'd0);
         if (k != wr_k) chk({tag, "_busy"}, {31'b0, rdata[2]}, 32'd1);
      end
      busWe = 1'b0;
      exp_q.delete();
   endtask

   task automatic chk_idle(input string tag);
      @(negedge clk);
      chk({tag, "_tx_idle"}, {31'b0, tx}, 32'd1);
      chk({tag, "_irq_idle"}, {31'b0, irq_txempty}, 32'd1);
      chk_rd({tag, "_status_idle"}, A_ST, 32'h2);
   endtask

   initial begin
      reset    = 1'b0;
      busWe    = 1'b0;
      busAddr  = 32'h0;
      busWData = 32'h0;
      strb     = SZ_W;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // reset state
      chk("rst_tx", {31'b0, tx}, 32'd1);
      chk("rst_irq", {31'b0, irq_txempty}, 32'd1);
      chk_rd("rst_rdata_unsel", 32'h0, 32'h0);
      chk_rd("rst_status", A_ST, 32'h2);
      chk_rd("rst_baud", A_BAUD, 32'd868);
      chk_rd("rst_ctrl", A_CTRL, 32'h0);
      @(negedge clk);

      // 1: single 0xA5 frame at 4 clocks per bit
      bus_wr(A_BAUD, 32'd4, SZ_W);
      bus_wr(A_CTRL, 32'd1, SZ_W);
      bus_wr(A_TX, 32'hFFFF_FFA5, SZ_B);
      add_frame(8'hA5, 4);
      watch("t1", 0, 32'h0);
      chk_idle("t1");

      // 2: overflow with tx disabled, clear, then four back-to-back frames
      @(negedge clk);
      bus_wr(A_CTRL, 32'd0, SZ_W);
      bus_wr(A_TX, 32'h11, SZ_B);
      bus_wr(A_TX, 32'h22, SZ_B);
      bus_wr(A_TX, 32'h33, SZ_B);
      bus_wr(A_TX, 32'h44, SZ_B);
      bus_wr(A_TX, 32'h55, SZ_B);
      chk_rd("t2_status_ovf", A_ST, 32'h9);
      chk_rd("t2_txdata_rd", A_TX, 32'h0);
      @(negedge clk);
      bus_wr(A_ST, 32'h8, SZ_B);
      chk_rd("t2_status_clr", A_ST, 32'h1);
      @(negedge clk);
      bus_wr(A_CTRL, 32'd1, SZ_W);
      add_frame(8'h11, 4);
      add_frame(8'h22, 4);
      add_frame(8'h33, 4);
      add_frame(8'h44, 4);
      watch("t2", 0, 32'h0);
      chk_idle("t2");

      // 3: zero divisor, then a 2->6 change during data bit 3
      @(negedge clk);
      bus_wr(A_BAUD, 32'd0, SZ_W);
      bus_wr(A_TX, 32'h3C, SZ_B);
      add_frame(8'h3C, 1);
      watch("t3a", 0, 32'h0);
      chk_idle("t3a");
      @(negedge clk);
      bus_wr(A_BAUD, 32'd2, SZ_W);
      bus_wr(A_TX, 32'hC3, SZ_B);
      add_bits(1'b0, 2);
      for (int i = 0; i < 4; i++) add_bits(1'(8'hC3 >> i), 2);
      for (int i = 4; i < 8; i++) add_bits(1'(8'hC3 >> i), 6);
      add_bits(1'b1, 6);
      watch("t3b", 10, 32'd6);
      chk_idle("t3b");

      // 4: sub-word writes to BAUDDIV and decode of a foreign window
      @(negedge clk);
      bus_wr(A_BAUD, 32'hFFFF_FFFF, SZ_W);
      chk_rd("t4_baud_sw", A_BAUD, 32'h0000_FFFF);
      @(negedge clk);
      bus_wr(A_BAUD, 32'hAAAA_AA12, SZ_B);
      chk_rd("t4_baud_sb", A_BAUD, 32'h0000_FF12);
      chk_rd("t4_unsel", 32'h1000_3000, 32'h0);
      @(negedge clk);
      bus_wr(32'h1000_3008, 32'h1234, SZ_W);
      chk_rd("t4_baud_foreign_wr", A_BAUD, 32'h0000_FF12);
      @(negedge clk);
      bus_wr(A_BAUD, 32'h5678_0003, SZ_H);
      chk_rd("t4_baud_sh", A_BAUD, 32'h0000_0003);
      chk_rd("t4_ctrl", A_CTRL, 32'h1);

      // 5: asynchronous reset during data bit 4, with a byte still queued
      @(negedge clk);
      bus_wr(A_CTRL, 32'd0, SZ_W);
      bus_wr(A_BAUD, 32'd2, SZ_W);
      bus_wr(A_TX, 32'hA5, SZ_B);
      bus_wr(A_TX, 32'h77, SZ_B);
      bus_wr(A_CTRL, 32'd1, SZ_W);
      repeat (11) @(negedge clk);
      chk("t5_data4_tx", {31'b0, tx}, 32'd0);
      reset = 1'b0;
      #1;
      chk("t5_async_tx", {31'b0, tx}, 32'd1);
      chk("t5_async_irq", {31'b0, irq_txempty}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      chk_rd("t5_status", A_ST, 32'h2);
      chk_rd("t5_baud", A_BAUD, 32'd868);
      chk_rd("t5_ctrl", A_CTRL, 32'h0);
      repeat (3) @(negedge clk);
      chk("t5_tx_hold", {31'b0, tx}, 32'd1);

      // 6: push on the same edge as the pop of the last entry
      bus_wr(A_BAUD, 32'd2, SZ_W);
      bus_wr(A_CTRL, 32'd1, SZ_W);
      bus_wr(A_TX, 32'h81, SZ_B);
      bus_wr(A_TX, 32'h42, SZ_B);
      chk("t6_start_tx", {31'b0, tx}, 32'd0);
      chk_rd("t6_status", A_ST, 32'h4);
      add_frame(8'h81, 2);
      void'(exp_q.pop_front());
      add_frame(8'h42, 2);
      watch("t6", 0, 32'h0);
      chk_idle("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
